// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state/direction types and default sizing
// for the SCAN elevator car controller.
package elevator_pkg;

   typedef enum logic [1:0] {IDLE, OPEN, MOVE} state_t;
   typedef enum logic [1:0] {NONE, UP, DN} dir_t;

   localparam int DEF_FLOORS = 4;
   localparam int DEF_TRAVEL = 4;
   localparam int DEF_DOOR   = 3;
   localparam int DEF_TMR_W  = 8;

endpackage

// File: rtl/elevator_call_reg.sv
// elevator_call_reg: latched car/hall calls with set/clear masks and
// above/below/at reductions around a floor index.
module elevator_call_reg
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_FLOORS,
   parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] set_car,
   input  logic [NUM_FLOORS-1:0] set_up,
   input  logic [NUM_FLOORS-1:0] set_dn,
   input  logic [NUM_FLOORS-1:0] clr_car,
   input  logic [NUM_FLOORS-1:0] clr_up,
   input  logic [NUM_FLOORS-1:0] clr_dn,
   input  logic [FLOOR_W-1:0]    idx,
   output logic [NUM_FLOORS-1:0] car,
   output logic [NUM_FLOORS-1:0] up,
   output logic [NUM_FLOORS-1:0] dn,
   output logic                  car_at,
   output logic                  up_at,
   output logic                  dn_at,
   output logic                  any_above,
   output logic                  any_below,
   output logic                  any_at
);

   logic [NUM_FLOORS-1:0] up_ok;
   logic [NUM_FLOORS-1:0] dn_ok;
   logic [NUM_FLOORS-1:0] any_call;

   // no up call from the top floor, no down call from the bottom
   always_comb begin
      up_ok = '1;
      up_ok[NUM_FLOORS-1] = 1'b0;
      dn_ok = '1;
      dn_ok[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         car <= '0;
         up  <= '0;
         dn  <= '0;
      end else begin
         car <= (car | set_car) & ~clr_car;
         up  <= (up | (set_up & up_ok)) & ~clr_up;
         dn  <= (dn | (set_dn & dn_ok)) & ~clr_dn;
      end
   end

   assign any_call = car | up | dn;
   assign car_at   = car[idx];
   assign up_at    = up[idx];
   assign dn_at    = dn[idx];
   assign any_at   = any_call[idx];

   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i > int'(idx)) any_above = any_above | any_call[i];
         if (i < int'(idx)) any_below = any_below | any_call[i];
      end
   end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor car controller serving calls in SCAN
// order, with one shared timer for travel and door dwell.
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS    = DEF_FLOORS,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int TRAVEL_CYCLES = DEF_TRAVEL,
   parameter int DOOR_CYCLES   = DEF_DOOR,
   parameter int TMR_W         = DEF_TMR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] car_call,
   input  logic [NUM_FLOORS-1:0] hall_up,
   input  logic [NUM_FLOORS-1:0] hall_dn,
   input  logic                  door_open_req,
   input  logic                  door_close_req,
   input  logic                  door_sensor,
   output logic [FLOOR_W-1:0]    floor,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] car_lamp,
   output logic [NUM_FLOORS-1:0] hall_up_lamp,
   output logic [NUM_FLOORS-1:0] hall_dn_lamp
);

   localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [TMR_W-1:0] T_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
   localparam logic [TMR_W-1:0] D_LOAD = TMR_W'(DOOR_CYCLES - 1);

   state_t state;
   dir_t   dir;
   dir_t   rev;
   logic [TMR_W-1:0]      tmr;
   logic [FLOOR_W-1:0]    nxt_floor;
   logic [FLOOR_W-1:0]    idx;
   logic [NUM_FLOORS-1:0] hot;
   logic [NUM_FLOORS-1:0] clr_car;
   logic [NUM_FLOORS-1:0] clr_up;
   logic [NUM_FLOORS-1:0] clr_dn;
   logic arrive, stop, hold, new_call;
   logic ahead, dir_at, go_up, go_dn;
   logic car_at, up_at, dn_at;
   logic any_above, any_below, any_at;
   logic hu_here, hd_here;

   elevator_call_reg #(
      .NUM_FLOORS(NUM_FLOORS),
      .FLOOR_W   (FLOOR_W)
   ) u_calls (
      .clk      (clk),
      .reset    (reset),
      .set_car  (car_call),
      .set_up   (hall_up),
      .set_dn   (hall_dn),
      .clr_car  (clr_car),
      .clr_up   (clr_up),
      .clr_dn   (clr_dn),
      .idx      (idx),
      .car      (car_lamp),
      .up       (hall_up_lamp),
      .dn       (hall_dn_lamp),
      .car_at   (car_at),
      .up_at    (up_at),
      .dn_at    (dn_at),
      .any_above(any_above),
      .any_below(any_below),
      .any_at   (any_at)
   );

   always_comb begin
      nxt_floor = floor;
      if (dir == UP && floor != TOP)
         nxt_floor = floor + 1'b1;
      else if (dir == DN && floor != '0)
         nxt_floor = floor - 1'b1;
   end

   // on the arrival cycle all decisions look at the floor being entered
   assign arrive = (state == MOVE) && (tmr == '0);
   assign idx    = arrive ? nxt_floor : floor;

   assign hu_here = hall_up[floor] && (floor != TOP);
   assign hd_here = hall_dn[floor] && (floor != '0);

   always_comb begin
      ahead    = 1'b0;
      dir_at   = up_at | dn_at;
      go_up    = any_above;
      go_dn    = !any_above && any_below;
      rev      = NONE;
      new_call = car_call[floor] | hu_here | hd_here;
      unique case (1'b1)
         dir == UP: begin
            ahead    = any_above;
            dir_at   = up_at;
            go_up    = any_above;
            go_dn    = !any_above && any_below;
            rev      = any_below ? DN : NONE;
            new_call = car_call[floor] | hu_here;
         end
         dir == DN: begin
            ahead    = any_below;
            dir_at   = dn_at;
            go_dn    = any_below;
            go_up    = !any_below && any_above;
            rev      = any_above ? UP : NONE;
            new_call = car_call[floor] | hd_here;
         end
         default: ;
      endcase
   end

   // with nothing ahead, any call left at this floor is a hall call
   assign stop = car_at | dir_at | !ahead;
   assign hold = door_sensor | door_open_req | new_call;

   always_comb begin
      hot = '0;
      hot[idx] = 1'b1;
      clr_car = '0;
      clr_up  = '0;
      clr_dn  = '0;
      unique case (1'b1)
         state == IDLE: begin
            if (any_at) begin
               clr_car = hot;
               clr_up  = hot;
               clr_dn  = hot;
            end
         end
         state == OPEN: begin
            clr_car = hot;
            if (dir != DN) clr_up = hot;
            if (dir != UP) clr_dn = hot;
         end
         state == MOVE: begin
            if (arrive && stop) begin
               clr_car = hot;
               if (dir == UP || !ahead) clr_up = hot;
               if (dir == DN || !ahead) clr_dn = hot;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         dir         <= NONE;
         tmr         <= '0;
         floor       <= '0;
         moving_up   <= 1'b0;
         moving_down <= 1'b0;
         door_open   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_at || (!go_up && !go_dn && door_open_req)) begin
                  state     <= OPEN;
                  tmr       <= D_LOAD;
                  door_open <= 1'b1;
               end else if (go_up) begin
                  state     <= MOVE;
                  dir       <= UP;
                  tmr       <= T_LOAD;
                  moving_up <= 1'b1;
               end else if (go_dn) begin
                  state       <= MOVE;
                  dir         <= DN;
                  tmr         <= T_LOAD;
                  moving_down <= 1'b1;
               end
            end
            MOVE: begin
               if (!arrive) begin
                  tmr <= tmr - 1'b1;
               end else begin
                  floor <= nxt_floor;
                  if (stop) begin
                     state       <= OPEN;
                     tmr         <= D_LOAD;
                     door_open   <= 1'b1;
                     moving_up   <= 1'b0;
                     moving_down <= 1'b0;
                     if (!ahead) dir <= rev;
                  end else begin
                     tmr <= T_LOAD;
                  end
               end
            end
            OPEN: begin
               if (hold) begin
                  tmr <= D_LOAD;
               end else if (tmr == '0) begin
                  door_open <= 1'b0;
                  if (go_up) begin
                     state     <= MOVE;
                     dir       <= UP;
                     tmr       <= T_LOAD;
                     moving_up <= 1'b1;
                  end else if (go_dn) begin
                     state       <= MOVE;
                     dir         <= DN;
                     tmr         <= T_LOAD;
                     moving_down <= 1'b1;
                  end else begin
                     state <= IDLE;
                     dir   <= NONE;
                  end
               end else if (door_close_req) begin
                  tmr <= '0;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/elevator_scan_ctrl.md
# elevator_scan_ctrl

Parametrised N-floor elevator car controller. It latches car and hall calls, serves them in SCAN order (continue in the current direction while calls remain ahead, then reverse), and times floor-to-floor travel and door dwell with a shared down-counter. It is the multi-floor successor to the fixed 4-floor controller and sits between the button/sensor input synchronisers and the motor/door drivers.

## Interface
Parameters:
- NUM_FLOORS, 4: floor count, at least 2.
- FLOOR_W, $clog2(NUM_FLOORS): floor index width.
- TRAVEL_CYCLES, 4: cycles to move one floor, at least 1.
- DOOR_CYCLES, 3: door dwell cycles, at least 1.
- TMR_W, 8: timer width; must hold max(TRAVEL_CYCLES, DOOR_CYCLES).

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- car_call, in, NUM_FLOORS: in-car floor buttons, one bit per floor, level or pulse.
- hall_up, in, NUM_FLOORS: hall up buttons. Bit NUM_FLOORS-1 is ignored.
- hall_dn, in, NUM_FLOORS: hall down buttons. Bit 0 is ignored.
- door_open_req, in, 1: door-open button.
- door_close_req, in, 1: door-close button.
- door_sensor, in, 1: doorway obstructed.
- floor, out, FLOOR_W: current or last-passed floor.
- moving_up, out, 1: car travelling up.
- moving_down, out, 1: car travelling down.
- door_open, out, 1: door commanded open.
- car_lamp, out, NUM_FLOORS: pending car calls.
- hall_up_lamp, out, NUM_FLOORS: pending hall-up calls.
- hall_dn_lamp, out, NUM_FLOORS: pending hall-down calls.

## Operation
- State: FSM {IDLE, OPEN, MOVE}, direction register dir ∈ {NONE, UP, DN}, timer tmr.
- Pending registers: each input bit ORs into its pending bit every cycle. Lamps equal the pending registers. Ignored bits stay 0.
- "Ahead" means any pending bit strictly above floor (for UP) or strictly below it (for DN).
- Stop condition at floor f: car_call[f], or the hall call in dir at f, or no calls ahead and any hall call at f.

IDLE (dir=NONE, door closed):
- Any call at floor → OPEN. Clear all pending at floor.
- Else any call above → dir=UP, MOVE, tmr=TRAVEL_CYCLES-1.
- Else any call below → dir=DN, MOVE.
- door_open_req → OPEN.

MOVE:
- tmr decrements. At 0, floor ±1 per dir.
- On arrival at the new floor:
  - If the stop condition holds → OPEN. Clear car_call[f] and the dir-matching hall bit. If nothing is ahead, also clear the opposite hall bit and reverse dir (NONE if no calls anywhere).
  - Otherwise, reload tmr and continue MOVE.
- Button inputs never alter motion mid-floor.

OPEN:
- door_open=1, tmr loaded DOOR_CYCLES-1.
- door_sensor, door_open_req, or a new call at the current floor in the served direction reloads tmr. Such calls are not latched.
- door_close_req with door_sensor=0 forces tmr to 0.
- At tmr==0 with sensor clear, the door closes:
  - Calls ahead in dir → MOVE.
  - Else calls behind → reverse dir, MOVE.
  - Else → IDLE, dir=NONE.
- The door never closes while door_sensor=1.

Boundaries:
- floor never leaves 0..NUM_FLOORS-1. UP never applies at the top floor, DN never at floor 0.
- Simultaneous set and clear of the same pending bit: the clear wins only for the floor being opened at. All others set.
- reset mid-travel returns the car to floor 0 logically, with no motion.

## Timing
- Reset values:
  - floor=0, dir=NONE, state IDLE.
  - All lamps, moving_up, moving_down, door_open = 0.
- Pending bit and lamp rise 1 cycle after the input is sampled.
- IDLE to first movement output: 1 cycle after the lamp is visible.
- Floor-to-floor travel: TRAVEL_CYCLES cycles per floor. floor updates on the last cycle.
- Door dwell: DOOR_CYCLES cycles minimum after the last reload.
- moving_up/moving_down are registered and equal (state==MOVE && dir==UP/DN). They are never both 1.
- door_open and moving_* are never both 1.

## Structure
- Shared package elevator_pkg holds:
  - state enum {IDLE, OPEN, MOVE} and dir enum {NONE, UP, DN};
  - default parameter constants.
- Sub-module elevator_call_reg: the pending register bank with set/clear masks. It also outputs any_above/any_below/any_at reductions for a given floor index.
- The FSM, timer and floor counter live in the top module.

## Test plan
- Reset, then car_call[3] pulse (NUM_FLOORS=4, TRAVEL=4, DOOR=3) → moving_up for 12 cycles, floor steps 1, 2, 3; door_open for 3 cycles; car_lamp[3] cleared on arrival.
- At floor 0, hall_dn[2] and car_call[1] pending → stops at 1 (door opens), then 2 (hall_dn_lamp[2] cleared), then IDLE.
- At floor 3 heading down with calls at 1 and car_call[3] re-pressed mid-travel → serves 1 first, then reverses up to 3.
- door_sensor held for 10 cycles during OPEN → door_open stays 1 throughout and closes 3 cycles after release. door_close_req with the sensor clear → closes next cycle.
- hall_up[3] and hall_dn[0] pulses → lamps stay 0 and the car stays IDLE.
- reset asserted mid-MOVE at floor 2 → next cycle floor=0, all outputs 0, pending cleared.
